axi_rd_responder: RTL and testbench
===================================

AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 1, meaning AR/R ID width.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning data width; only 32 is supported.
REQ-004 SHALL have parameter C_MEM_AWIDTH, default 10, meaning log2 of the memory word count (default 1024 words, 4 KB).
REQ-005 SHALL have parameter C_BASE_ADDR, default 32'h0000_0000, meaning byte base address; aligned to 4 << C_MEM_AWIDTH.
REQ-006 SHALL have one clock and an asynchronous, active-high reset, with ports: CLK in 1, clock; RST in 1, asynchronous active-high reset.
REQ-007 SHALL have these ports: S_AXI_ARID in ID_W; S_AXI_ARADDR in ADDR_W; S_AXI_ARLEN in 8; S_AXI_ARSIZE in 3; S_AXI_ARBURST in 2; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-008 SHALL have these ports: S_AXI_RID out ID_W; S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RLAST out 1; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-009 SHALL have these ports: LOAD_WE in 1, preload write strobe; LOAD_ADDR in C_MEM_AWIDTH, word index; LOAD_DATA in 32, preload data; BUSY out 1, high while a burst is accepted but not completed.

Function
REQ-010 SHALL implement states S_IDLE, S_READ, S_DRAIN; transitions: S_IDLE->S_READ on ARVALID&&ARREADY; S_READ->S_DRAIN when the last beat address is issued to memory; S_DRAIN->S_IDLE on the RVALID&&RREADY&&RLAST handshake.
REQ-011 SHALL assert ARREADY only in S_IDLE; exactly one outstanding burst; ARID/ARLEN/ARBURST/ARADDR are latched at the handshake.
REQ-012 SHALL present beat 0 (RVALID=1) two cycles after the AR handshake cycle.
REQ-013 SHALL sustain one beat per cycle while RREADY=1.
REQ-014 SHALL hold RDATA/RRESP/RLAST/RID stable while RVALID=1 and RREADY=0; no beat is lost or duplicated under any RREADY pattern.
REQ-015 SHALL issue a memory read only when the output buffer has space counting the in-flight read (1-cycle synchronous memory latency).
REQ-016 SHALL, for INCR bursts, advance the address by 4 each beat; for FIXED bursts, keep the address constant.
REQ-017 SHALL compute the word index as address[C_MEM_AWIDTH+1:2] with modulo wrap-around.
REQ-018 SHALL emit ARLEN+1 beats, with RLAST=1 only on beat ARLEN; ARLEN=0 yields one beat with RLAST=1.
REQ-019 SHALL return RRESP=2'b11 (DECERR) and RDATA=0 for a beat whose address[ADDR_W-1:C_MEM_AWIDTH+2] does not match the base; otherwise RRESP=2'b00.
REQ-020 SHALL return RRESP=2'b10 (SLVERR) and RDATA=0 on all beats when ARSIZE!=3'b010, while keeping the full beat count.
REQ-021 SHALL write LOAD_DATA at LOAD_ADDR when LOAD_WE=1 in any state; a simultaneous read of the same word returns the old data (read-first).
REQ-022 SHALL drive RID equal to the latched ARID on every beat.
REQ-023 SHALL assert BUSY from the cycle after the AR handshake through the RLAST handshake cycle.

Reset
REQ-024 SHALL, while RST=1, hold ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, BUSY=0, state=S_IDLE, and the buffer empty; memory contents are not reset.
REQ-025 SHALL, on reset mid-burst, abandon the burst with no further beats, and assert ARREADY=1 in the first cycle after RST deasserts.

Configuration
REQ-026 SHALL, with AXI_RD_WRAP_EN defined, support WRAP bursts (ARBURST=2'b10, ARLEN in {1,3,7,15}), wrapping at the (ARLEN+1)*4-byte aligned boundary.
REQ-027 SHALL, without AXI_RD_WRAP_EN, answer WRAP and reserved bursts (2'b11) with SLVERR on ARLEN+1 beats.

Structure
REQ-028 SHALL place the RRESP codes (OKAY/SLVERR/DECERR), the burst encodings, and the state encodings in a shared package.
REQ-029 SHALL instantiate one sub-module, rd_skid_buf: a 2-entry FIFO holding {data, resp, last}.

Verification
REQ-030 SHALL cover: preload words 0..31 with 0x1000+i, then INCR ARADDR=0x0 ARLEN=0x1f with RREADY=1 -> 32 beats 0x1000..0x101F on consecutive cycles, RLAST on beat 31, first beat 2 cycles after the handshake.
REQ-031 SHALL cover: the same burst with RREADY toggling 1,0,0,1 -> all 32 values in order, no gaps or repeats, outputs stable while stalled.
REQ-032 SHALL cover: ARADDR=0x0000_1000 (out of range) with ARLEN=3 -> 4 beats of RRESP=DECERR, RDATA=0, RLAST on beat 3.
REQ-033 SHALL cover: ARSIZE=3'b001 with ARLEN=1 -> 2 beats of SLVERR; FIXED ARADDR=0x10 with ARLEN=2 -> 3 beats of 0x1004.
REQ-034 SHALL cover: RST asserted at beat 5 of a 32-beat burst -> RVALID=0 immediately, ARREADY=1 one cycle after release, and a new ARLEN=0 read of 0x8 returns 0x1002 with RLAST.
REQ-035 SHALL cover, with AXI_RD_WRAP_EN defined: WRAP ARADDR=0x18 with ARLEN=3 -> data order 0x1006, 0x1007, 0x1004, 0x1005.

Source files
------------

// File: rtl/axi_rd_responder_pkg.sv
// Shared types and encodings for the AXI read responder.
// Response codes, burst encodings, FSM states and the buffered beat record.
package axi_rd_responder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    function automatic logic wrap_len_ok(logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI4 read address / read data channel bundle.
// Master drives AR and RREADY; slave drives ARREADY and R.
interface axi_rd_responder_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   S_AXI_ARID;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [7:0]        S_AXI_ARLEN;
    logic [2:0]        S_AXI_ARSIZE;
    logic [1:0]        S_AXI_ARBURST;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [ID_W-1:0]   S_AXI_RID;
    logic [DATA_W-1:0] S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RLAST;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN,
        output S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP,
        input  S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN,
        input  S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP,
        output S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi_rd_responder_rd_skid_buf.sv
// Two-entry beat FIFO with fall-through when empty.
// A beat arriving into an empty buffer is presented in the same cycle.
module rd_skid_buf
    import axi_rd_responder_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    input  beat_t      in_beat,
    output logic       out_valid,
    output beat_t      out_beat,
    input  logic       out_ready,
    output logic [1:0] count
);
    beat_t      ent [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] cnt_q;
    logic       empty;
    logic       push;
    logic       pop;

    assign empty     = (cnt_q == 2'd0);
    assign push      = in_valid && !(empty && out_ready);
    assign pop       = !empty && out_ready;
    assign out_valid = !empty || in_valid;
    assign out_beat  = empty ? in_beat : ent[rd_ptr];
    assign count     = cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) ent[wr_ptr] <= in_beat;
    end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-only memory responder with preload port and one outstanding burst.
// Define AXI_RD_WRAP_EN to accept WRAP bursts; otherwise they answer SLVERR.
module axi_rd_responder
    import axi_rd_responder_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_AWIDTH       = 10,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
    input  logic                          CLK,
    input  logic                          RST,
    axi_rd_responder_if.slave             s_axi,
    input  logic                          LOAD_WE,
    input  logic [C_MEM_AWIDTH-1:0]       LOAD_ADDR,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] LOAD_DATA,
    output logic                          BUSY
);
    localparam int AW  = C_MEM_AWIDTH;
    localparam int ADW = C_S_AXI_ADDR_WIDTH;

    state_t                        state_q, state_d;
    logic [C_S_AXI_ID_WIDTH-1:0]   id_q;
    logic [ADW-1:0]                addr_q, addr_nx;
    logic [7:0]                    len_q, cnt_q;
    logic [1:0]                    burst_q;
    logic                          serr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] mem [2**AW];
    logic [C_S_AXI_DATA_WIDTH-1:0] mem_q;
    logic                          rd_valid_q;
    logic [1:0]                    resp_q;
    logic                          last_q;

    logic       ar_hs, r_hs, issue, last_beat;
    logic       in_range, ar_serr, out_valid;
    logic [1:0] beat_resp, fifo_cnt;
    beat_t      in_beat, out_beat;

    assign s_axi.S_AXI_ARREADY = (state_q == S_IDLE) && !RST;
    assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign r_hs  = out_valid && s_axi.S_AXI_RREADY;

    // Occupancy plus the beat landing from memory must leave room for one more.
    assign issue = (state_q == S_READ) &&
                   (({1'b0, fifo_cnt} + {2'b0, rd_valid_q}) < 3'd2);
    assign last_beat = (cnt_q == len_q);
    assign in_range  = addr_q[ADW-1:AW+2] == C_BASE_ADDR[ADW-1:AW+2];
    assign beat_resp = serr_q   ? RESP_SLVERR :
                       in_range ? RESP_OKAY   : RESP_DECERR;

    always_comb begin
        ar_serr = (s_axi.S_AXI_ARSIZE != 3'b010) ||
                  (s_axi.S_AXI_ARBURST == BURST_RSVD);
`ifdef AXI_RD_WRAP_EN
        if (s_axi.S_AXI_ARBURST == BURST_WRAP &&
            !wrap_len_ok(s_axi.S_AXI_ARLEN)) ar_serr = 1'b1;
`else
        if (s_axi.S_AXI_ARBURST == BURST_WRAP) ar_serr = 1'b1;
`endif
    end

    always_comb begin
`ifdef AXI_RD_WRAP_EN
        logic [ADW-1:0] wmask;
        wmask = ADW'({len_q, 2'b11});
`endif
        addr_nx = addr_q;
        unique case (burst_q)
            BURST_INCR: addr_nx = addr_q + ADW'(4);
`ifdef AXI_RD_WRAP_EN
            BURST_WRAP: addr_nx = (addr_q & ~wmask) |
                                  ((addr_q + ADW'(4)) & wmask);
`endif
            default:    addr_nx = addr_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ar_hs) state_d = S_READ;
            S_READ:  if (issue && last_beat) state_d = S_DRAIN;
            S_DRAIN: if (r_hs && out_beat.last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            burst_q    <= BURST_FIXED;
            serr_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            resp_q     <= RESP_OKAY;
            last_q     <= 1'b0;
        end else begin
            rd_valid_q <= issue;
            if (ar_hs) begin
                id_q    <= s_axi.S_AXI_ARID;
                addr_q  <= s_axi.S_AXI_ARADDR;
                len_q   <= s_axi.S_AXI_ARLEN;
                burst_q <= s_axi.S_AXI_ARBURST;
                serr_q  <= ar_serr;
                cnt_q   <= '0;
            end
            if (issue) begin
                addr_q <= addr_nx;
                cnt_q  <= cnt_q + 8'd1;
                resp_q <= beat_resp;
                last_q <= last_beat;
            end
        end
    end

    // Read-first: a same-cycle preload write is seen by later reads only.
    always_ff @(posedge CLK) begin
        if (LOAD_WE) mem[LOAD_ADDR] <= LOAD_DATA;
        if (issue)   mem_q <= mem[addr_q[AW+1:2]];
    end

    always_comb begin
        in_beat.data = '0;
        in_beat.resp = RESP_OKAY;
        in_beat.last = 1'b0;
        if (rd_valid_q) begin
            if (resp_q == RESP_OKAY) in_beat.data = mem_q;
            in_beat.resp = resp_q;
            in_beat.last = last_q;
        end
    end

    rd_skid_buf u_buf (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (rd_valid_q),
        .in_beat   (in_beat),
        .out_valid (out_valid),
        .out_beat  (out_beat),
        .out_ready (s_axi.S_AXI_RREADY),
        .count     (fifo_cnt)
    );

    assign s_axi.S_AXI_RID    = id_q;
    assign s_axi.S_AXI_RDATA  = out_beat.data;
    assign s_axi.S_AXI_RRESP  = out_beat.resp;
    assign s_axi.S_AXI_RLAST  = out_beat.last;
    assign s_axi.S_AXI_RVALID = out_valid;
    assign BUSY = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: table of bursts, reset abort, random bursts.
// Expected beats come from an address-arithmetic model of the memory.
module tb_axi_rd_responder;
    import axi_rd_responder_pkg::*;

    localparam int IDW = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LOAD_WE = 1'b0;
    logic [9:0]  LOAD_ADDR = '0;
    logic [31:0] LOAD_DATA = '0;
    logic        BUSY;

    always #5 CLK = ~CLK;

    axi_rd_responder_if #(.ID_W(IDW), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_rd_responder #(.C_S_AXI_ID_WIDTH(IDW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .s_axi     (bus.slave),
        .LOAD_WE   (LOAD_WE),
        .LOAD_ADDR (LOAD_ADDR),
        .LOAD_DATA (LOAD_DATA),
        .BUSY      (BUSY)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    typedef struct {
        logic [31:0]    addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
        int             mode;
        logic [IDW-1:0] id;
        logic [1:0]     resp;
        logic [31:0]    first;
        bit             lat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    bit          wrap_en;
    logic [31:0] mem_m [1024];
    exp_t        exp_q [$];
    exp_t        first_b;
    bit          aborted;

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void build_exp(logic [31:0] a0, logic [7:0] len,
                                      logic [2:0] size, logic [1:0] burst);
        bit          serr;
        logic [31:0] bytes, base, off, a;
        exp_t        e;
        serr = (size != 3'b010) || (burst == 2'b11) ||
               (burst == 2'b10 && (!wrap_en ||
                !(len == 1 || len == 3 || len == 7 || len == 15)));
        bytes = (32'(len) + 1) * 4;
        base  = a0 - (a0 % bytes);
        exp_q.delete();
        for (int b = 0; b <= int'(len); b++) begin
            if (burst == 2'b00) a = a0;
            else if (burst == 2'b10) begin
                off = (a0 - base) + 32'(4 * b);
                a = base + (off % bytes);
            end else a = a0 + 32'(4 * b);
            if (serr) e.resp = 2'b10;
            else if (a >= 32'h1000) e.resp = 2'b11;
            else e.resp = 2'b00;
            e.data = (e.resp == 2'b00) ? mem_m[a[11:2]] : 32'h0;
            e.last = (b == int'(len));
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic rr_pat(int mode, int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int mode, input logic [IDW-1:0] id,
                            input bit chk_lat, input int abort_at);
        int   n, k, got, cycles;
        bit   stalled;
        exp_t prev, e;
        logic rr;
        build_exp(addr, len, size, burst);
        bus.S_AXI_ARID    = id;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARLEN   = len;
        bus.S_AXI_ARSIZE  = size;
        bus.S_AXI_ARBURST = burst;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b0;
        n = 0;
        while (!bus.S_AXI_ARREADY && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 50) check("ar_timeout", 0, 1);
        @(posedge CLK); #1;
        bus.S_AXI_ARVALID = 1'b0;
        check("hs_cycle", {bus.S_AXI_RVALID, BUSY}, 2'b01);
        k = 0; got = 0; cycles = 0; stalled = 0; aborted = 0;
        while (exp_q.size() > 0 && cycles < 400) begin
            @(posedge CLK); #1;
            cycles++;
            if (chk_lat && cycles == 1)
                check("latency", bus.S_AXI_RVALID, 1'b1);
            if (stalled)
                check("stall_hold",
                      {bus.S_AXI_RVALID, bus.S_AXI_RDATA,
                       bus.S_AXI_RRESP, bus.S_AXI_RLAST},
                      {1'b1, prev.data, prev.resp, prev.last});
            stalled = 0;
            if (bus.S_AXI_RVALID && abort_at >= 0 && got == abort_at) begin
                aborted = 1;
                break;
            end
            if (bus.S_AXI_RVALID) begin
                rr = rr_pat(mode, k);
                k++;
                bus.S_AXI_RREADY = rr;
                if (rr) begin
                    e = exp_q.pop_front();
                    check("beat", {bus.S_AXI_RDATA, bus.S_AXI_RRESP,
                                   bus.S_AXI_RLAST},
                          {e.data, e.resp, e.last});
                    check("beat_id", bus.S_AXI_RID, id);
                    if (got == 0) first_b = e;
                    if (got == 0) begin
                        first_b.data = bus.S_AXI_RDATA;
                        first_b.resp = bus.S_AXI_RRESP;
                    end
                    got++;
                end else begin
                    stalled = 1;
                    prev.data = bus.S_AXI_RDATA;
                    prev.resp = bus.S_AXI_RRESP;
                    prev.last = bus.S_AXI_RLAST;
                end
            end else begin
                bus.S_AXI_RREADY = 1'b0;
                if (mode == 0 && got > 0) check("gap", 0, 1);
            end
        end
        if (!aborted) begin
            if (exp_q.size() != 0) check("r_timeout", exp_q.size(), 0);
            @(posedge CLK); #1;
            bus.S_AXI_RREADY = 1'b0;
            check("done", {bus.S_AXI_RVALID, BUSY}, 2'b00);
        end
    endtask

    vec_t vecs [8];

    initial begin
`ifdef AXI_RD_WRAP_EN
        wrap_en = 1'b1;
`else
        wrap_en = 1'b0;
`endif
        bus.S_AXI_ARID = '0;
        bus.S_AXI_ARADDR = '0;
        bus.S_AXI_ARLEN = '0;
        bus.S_AXI_ARSIZE = 3'b010;
        bus.S_AXI_ARBURST = 2'b01;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_arready", bus.S_AXI_ARREADY, 1'b0);
        check("rst_rvalid", bus.S_AXI_RVALID, 1'b0);
        check("rst_rlast", bus.S_AXI_RLAST, 1'b0);
        check("rst_rresp", bus.S_AXI_RRESP, 2'b00);
        check("rst_rid", bus.S_AXI_RID, '0);
        check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
        check("rst_busy", BUSY, 1'b0);
        RST = 1'b0;
        #1;
        check("rel_arready", bus.S_AXI_ARREADY, 1'b1);

        for (int i = 0; i < 1024; i++) begin
            if (i < 32) mem_m[i] = 32'h1000 + 32'(i);
            else if (i == 1022) mem_m[i] = 32'hDEAD_BEEF;
            else if (i == 1023) mem_m[i] = 32'hCAFE_F00D;
            else mem_m[i] = $urandom;
            LOAD_WE = 1'b1;
            LOAD_ADDR = 10'(i);
            LOAD_DATA = mem_m[i];
            @(posedge CLK); #1;
        end
        LOAD_WE = 1'b0;

        vecs[0] = '{32'h0, 8'd31, 3'd2, 2'd1, 0, 2'd1,
                    2'b00, 32'h1000, 1'b1};
        vecs[1] = '{32'h0, 8'd31, 3'd2, 2'd1, 1, 2'd2,
                    2'b00, 32'h1000, 1'b1};
        vecs[2] = '{32'h1000, 8'd3, 3'd2, 2'd1, 0, 2'd3,
                    2'b11, 32'h0, 1'b1};
        vecs[3] = '{32'h0, 8'd1, 3'd1, 2'd1, 0, 2'd0,
                    2'b10, 32'h0, 1'b1};
        vecs[4] = '{32'h10, 8'd2, 3'd2, 2'd0, 0, 2'd1,
                    2'b00, 32'h1004, 1'b1};
        if (wrap_en)
            vecs[5] = '{32'h18, 8'd3, 3'd2, 2'd2, 0, 2'd2,
                        2'b00, 32'h1006, 1'b1};
        else
            vecs[5] = '{32'h18, 8'd3, 3'd2, 2'd2, 0, 2'd2,
                        2'b10, 32'h0, 1'b1};
        vecs[6] = '{32'h8, 8'd2, 3'd2, 2'd3, 1, 2'd3,
                    2'b10, 32'h0, 1'b1};
        vecs[7] = '{32'hFF8, 8'd3, 3'd2, 2'd1, 1, 2'd0,
                    2'b00, 32'hDEAD_BEEF, 1'b1};

        for (int v = 0; v < 8; v++) begin
            do_burst(vecs[v].addr, vecs[v].len, vecs[v].size,
                     vecs[v].burst, vecs[v].mode, vecs[v].id,
                     vecs[v].lat, -1);
            check("vec_first", {first_b.data, first_b.resp},
                  {vecs[v].first, vecs[v].resp});
        end

        // Reset while beat 5 of a long burst is on the bus.
        do_burst(32'h0, 8'd31, 3'd2, 2'd1, 0, 2'd2, 1'b0, 5);
        check("abort_reached", aborted, 1'b1);
        bus.S_AXI_RREADY = 1'b0;
        RST = 1'b1;
        #1;
        check("abort_rvalid", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY, BUSY},
              3'b000);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        check("abort_arready", bus.S_AXI_ARREADY, 1'b1);
        exp_q.delete();
        do_burst(32'h8, 8'd0, 3'd2, 2'd1, 0, 2'd1, 1'b1, -1);
        check("abort_next", {first_b.data, first_b.resp}, {32'h1002, 2'b00});

        for (int r = 0; r < 30; r++) begin
            logic [31:0] ra;
            logic [2:0]  rs;
            ra = 32'($urandom_range(0, 32'h1FFF)) & ~32'h3;
            rs = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            do_burst(ra, 8'($urandom_range(0, 15)), rs,
                     2'($urandom_range(0, 3)), 2,
                     IDW'($urandom_range(0, 3)), 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
